// File: rtl/conv_decoder_par.sv
// Byte-parallel feed-forward decoder for the rate-1/3 K=7 tail-biting convolutional code (G0=133, G1=171, G2=165).
// Define CONV_DEC_CHECK_EN to build the G1/G2 parity checker and err_count accumulator.
module conv_decoder_par (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        code_block_length,
  input  logic [5:0]  init_state,
  input  logic [7:0]  q0,
  input  logic [7:0]  q1,
  input  logic [7:0]  q2,
  input  logic        empty0,
  input  logic        empty1,
  input  logic        empty2,
  output logic        rdreq,
  input  logic        out_afull,
  output logic [7:0]  dec_byte,
  output logic        dec_valid,
  output logic        busy,
  output logic        done,
  output logic [13:0] err_count,
  output logic        tail_mismatch
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} fsm_t;

  localparam logic [14:0] ERR_MAX = 15'd12288;

  fsm_t        fsm_q, fsm_d;
  logic        len_q, len_d;
  logic [5:0]  init_q, init_d;
  logic [5:0]  sr_q, sr_d;
  logic [9:0]  byte_cnt_q, byte_cnt_d;
  logic        rd_q, rd_d;
  logic [7:0]  dec_byte_q, dec_byte_d;
  logic        dec_valid_q, dec_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [13:0] err_count_q, err_count_d;
  logic        tail_q, tail_d;

  logic [9:0]  block_len;
  logic [5:0]  sr_next;
  logic [7:0]  dec_bits;
  logic [4:0]  err_inc;
  logic [14:0] err_sum;
  logic        c_bit;

  assign block_len = len_q ? 10'd768 : 10'd132;
  assign rdreq = (fsm_q == S_RUN) && !empty0 && !empty1 && !empty2 && !out_afull
                 && (byte_cnt_q < block_len);

`ifndef CONV_DEC_CHECK_EN
  logic unused_q12;
  assign unused_q12 = ^{q1, q2};
`endif

  // Unrolled 8-bit decode of the byte returned by the FIFOs; sr[0] is the newest bit.
  always_comb begin
    sr_next  = sr_q;
    dec_bits = 8'd0;
    err_inc  = 5'd0;
    c_bit    = 1'b0;
    for (int k = 0; k < 8; k++) begin
      c_bit = q0[k] ^ sr_next[1] ^ sr_next[2] ^ sr_next[4] ^ sr_next[5];
      dec_bits[7-k] = c_bit;
`ifdef CONV_DEC_CHECK_EN
      err_inc = err_inc
              + {4'd0, q1[k] ^ c_bit ^ sr_next[0] ^ sr_next[1] ^ sr_next[2] ^ sr_next[5]}
              + {4'd0, q2[k] ^ c_bit ^ sr_next[0] ^ sr_next[1] ^ sr_next[3] ^ sr_next[5]};
`endif
      sr_next = {sr_next[4:0], c_bit};
    end
  end

  assign err_sum = {1'b0, err_count_q} + {10'd0, err_inc};

  always_comb begin
    fsm_d       = fsm_q;
    len_d       = len_q;
    init_d      = init_q;
    sr_d        = sr_q;
    byte_cnt_d  = byte_cnt_q + {9'd0, rdreq};
    rd_d        = rdreq;
    dec_valid_d = rd_q;
    dec_byte_d  = rd_q ? dec_bits : dec_byte_q;
    done_d      = 1'b0;
    err_count_d = err_count_q;
    tail_d      = tail_q;

    if (rd_q) begin
      sr_d        = sr_next;
      err_count_d = (err_sum > ERR_MAX) ? ERR_MAX[13:0] : err_sum[13:0];
    end

    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          fsm_d       = S_RUN;
          len_d       = code_block_length;
          init_d      = init_state;
          sr_d        = init_state;
          byte_cnt_d  = 10'd0;
          err_count_d = 14'd0;
          tail_d      = 1'b0;
        end
      end
      S_RUN: begin
        if (byte_cnt_d == block_len) fsm_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Last byte has been folded into sr_q once nothing is left in flight.
        if (!rd_q) begin
          fsm_d  = S_DONE;
          done_d = 1'b1;
          tail_d = (sr_q != init_q);
        end
      end
      default: fsm_d = S_IDLE;
    endcase

    busy_d = (fsm_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= S_IDLE;
      len_q       <= 1'b0;
      init_q      <= 6'd0;
      sr_q        <= 6'd0;
      byte_cnt_q  <= 10'd0;
      rd_q        <= 1'b0;
      dec_byte_q  <= 8'd0;
      dec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_count_q <= 14'd0;
      tail_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      len_q       <= len_d;
      init_q      <= init_d;
      sr_q        <= sr_d;
      byte_cnt_q  <= byte_cnt_d;
      rd_q        <= rd_d;
      dec_byte_q  <= dec_byte_d;
      dec_valid_q <= dec_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_count_q <= err_count_d;
      tail_q      <= tail_d;
    end
  end

  assign dec_byte      = dec_byte_q;
  assign dec_valid     = dec_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_count     = err_count_q;
  assign tail_mismatch = tail_q;

endmodule
